lsu_controller: RTL and testbench

LSU_CONTROLLER -- requirements
Module: lsu_controller

---
 rtl/lsu_controller.sv | 177 +++++++++++++++++
 tb/tb_lsu_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_controller.sv
// lsu_controller -- single-access load/store unit between a core and a word memory.
//
// Accepts one load or store per start pulse, checks access legality, drives a
// held word-aligned memory request with byte-lane enables and lane-replicated
// store data, and returns a one-cycle done pulse with an error flag. Loads are
// shifted down to the addressed byte/half and sign- or zero-extended into rdata.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, is_store,      access request; is_store/funct3/addr/wdata are
//   funct3, addr, wdata   sampled with start while idle
//   busy                  high whenever an access is in flight
//   mem_req, mem_we,      memory request bundle, held and stable until
//   mem_addr, mem_be,     mem_ack or timeout
//   mem_wdata
//   mem_ack, mem_rdata    memory completion and read word
//   done, err             one-cycle completion pulse and its error flag
//   rdata                 extended load result, updated only on load ack
module lsu_controller #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;

    // Decode of the incoming request, only consumed in IDLE.
    logic        illegal;
    logic [3:0]  be_n;
    logic [31:0] wd_n;

    always_comb begin
        illegal = 1'b0;
        if (is_store)
            illegal = funct3[2] | (funct3[1:0] == 2'b11);
        else
            illegal = (funct3[1:0] == 2'b11) | (funct3 == 3'b110);
        // Halfword needs addr[0]=0, word needs addr[1:0]=0 (same rule for loads and stores).
        if (funct3[1:0] == 2'b01 && addr[0])
            illegal = 1'b1;
        if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)
            illegal = 1'b1;

        be_n = 4'b1111;
        wd_n = wdata;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    be_n = 4'b0001 << addr[1:0];
                    wd_n = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_n = 4'b0011 << addr[1:0];
                    wd_n = {2{wdata[15:0]}};
                end
                default: begin
                    be_n = 4'b1111;
                    wd_n = wdata;
                end
            endcase
        end
    end

    // Load extraction from the acknowledged word.
    logic [31:0] shifted;
    logic [31:0] load_ext;

    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b101:  load_ext = {16'h0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            wait_cnt  <= '0;
            f3_q      <= '0;
            off_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        f3_q      <= funct3;
                        off_q     <= addr[1:0];
                        mem_we    <= is_store;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_be    <= be_n;
                        mem_wdata <= wd_n;
                        wait_cnt  <= '0;
                        busy      <= 1'b1;
                        if (illegal) begin
                            // Rejected accesses never touch memory.
                            state <= S_RESP;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state   <= S_REQ;
                            mem_req <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        state   <= S_RESP;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        if (!mem_we)
                            rdata <= load_ext;
                    end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                        state   <= S_RESP;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: directed vector table, hand-written
// corner sequences (start while busy, ack while idle, reset mid-request) and
// randomized accesses checked against a plain-arithmetic reference model.
module tb_lsu_controller;

    localparam int MW = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, is_store, mem_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_rdata;
    logic        busy, mem_req, mem_we, done, err;
    logic [31:0] mem_addr, mem_wdata, rdata;
    logic [3:0]  mem_be;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] model_rdata = 32'h0;

    lsu_controller #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .done(done), .err(err), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: access size in bytes, legality, lanes and load result.
    function automatic void model(input logic st, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] mrd, output logic legal,
                                  output logic [3:0] be, output logic [31:0] mwd,
                                  output logic [31:0] ld);
        int sz;
        int off;
        logic [31:0] v;
        off = int'(a % 4);
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        legal = (sz != 0) && !(st && f3 > 3'd2) && ((a % sz) == 0);
        be    = st ? 4'((((1 << sz) - 1) << off) & 15) : 4'hF;
        if (sz == 1)      mwd = (wd & 32'hFF) * 32'h01010101;
        else if (sz == 2) mwd = (wd & 32'hFFFF) * 32'h00010001;
        else              mwd = wd;
        v = mrd / (32'd1 << (8 * off));
        if (sz == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v + 32'hFFFFFF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
        end
        ld = v;
    endfunction

    // One access: waits = ack after that many no-ack REQ cycles, <0 = never ack.
    // spam keeps start asserted (with an illegal request) for the whole residency.
    task automatic run_txn(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] mrd, input int waits, input logic spam,
                           input int exp_nreq, input logic exp_err,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd);
        int nreq = 0;
        int done_k = 0;
        logic err_o = 1'b0;
        logic unstable = 1'b0;
        logic stray = 1'b0;
        logic we0 = 1'b0;
        logic [3:0] be0 = '0;
        logic [31:0] a0 = '0, wd0 = '0, rd_o = '0;
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        for (int k = 1; k <= 40 && done_k == 0; k++) begin
            @(negedge clk);
            start = spam;
            if (spam) begin
                is_store = 1'b0; funct3 = 3'b111; addr = 32'hFFFF_FFF1; wdata = 32'h5A5A5A5A;
            end
            if (mem_req) begin
                if (nreq == 0) begin
                    a0 = mem_addr; be0 = mem_be; wd0 = mem_wdata; we0 = mem_we;
                end else if (a0 !== mem_addr || be0 !== mem_be || wd0 !== mem_wdata || we0 !== mem_we) begin
                    unstable = 1'b1;
                end
                nreq++;
                mem_ack   = (waits >= 0 && nreq - 1 == waits);
                mem_rdata = mrd;
            end else begin
                mem_ack = 1'b0;
            end
            if (done) begin
                done_k = k; err_o = err; rd_o = rdata;
            end
        end
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b0;
        check({tag, " busy_after"}, 32'(busy), 32'(0));
        check({tag, " nreq"}, nreq, exp_nreq);
        check({tag, " done_cycle"}, done_k, exp_nreq + 1);
        check({tag, " err"}, 32'(err_o), 32'(exp_err));
        check({tag, " rdata"}, rd_o, exp_rd);
        if (nreq > 0) begin
            check({tag, " mem_addr"}, a0, a & 32'hFFFF_FFFC);
            check({tag, " mem_we"}, 32'(we0), 32'(st));
            check({tag, " mem_be"}, 32'(be0), 32'(exp_be));
            if (st) check({tag, " mem_wdata"}, wd0, exp_wd);
            check({tag, " stable"}, 32'(unstable), 32'(0));
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done || mem_req || busy) stray = 1'b1;
        end
        check({tag, " quiet_after"}, 32'(stray), 32'(0));
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, wd, mrd;
        int          waits;
        int          exp_nreq;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic legal;
        logic [3:0] m_be;
        logic [31:0] m_wd, m_ld;
        logic st;
        logic [2:0] f3;
        logic [31:0] a, wd, mrd;
        int waits, enr;
        logic eerr, stray;

        vecs[0]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 0,  1,  1'b0, 4'hF, 32'h0,        32'hFFFFFF80};
        vecs[1]  = '{1'b1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0,        3,  4,  1'b0, 4'hC, 32'hBEEFBEEF, 32'hFFFFFF80};
        vecs[2]  = '{1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0,  0,  1'b1, 4'h0, 32'h0,        32'hFFFFFF80};
        vecs[3]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        0,  0,  1'b1, 4'h0, 32'h0,        32'hFFFFFF80};
        vecs[4]  = '{1'b0, 3'b101, 32'h2,   32'h0,        32'h12345678, -1, 15, 1'b1, 4'hF, 32'h0,        32'hFFFFFF80};
        vecs[5]  = '{1'b0, 3'b010, 32'h400, 32'h0,        32'hDEADBEEF, 2,  3,  1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
        vecs[6]  = '{1'b0, 3'b001, 32'h2,   32'h0,        32'h80011234, 0,  1,  1'b0, 4'hF, 32'h0,        32'hFFFF8001};
        vecs[7]  = '{1'b0, 3'b100, 32'h1,   32'h0,        32'h0000F000, 1,  2,  1'b0, 4'hF, 32'h0,        32'h000000F0};
        vecs[8]  = '{1'b1, 3'b000, 32'h3,   32'h12345678, 32'h0,        0,  1,  1'b0, 4'h8, 32'h78787878, 32'h000000F0};
        vecs[9]  = '{1'b1, 3'b010, 32'h8,   32'hCAFEF00D, 32'h0,        5,  6,  1'b0, 4'hF, 32'hCAFEF00D, 32'h000000F0};
        vecs[10] = '{1'b1, 3'b100, 32'h0,   32'h0,        32'h0,        0,  0,  1'b1, 4'h0, 32'h0,        32'h000000F0};
        vecs[11] = '{1'b1, 3'b001, 32'h1,   32'h0,        32'h0,        0,  0,  1'b1, 4'h0, 32'h0,        32'h000000F0};
        vecs[12] = '{1'b0, 3'b010, 32'h10,  32'h0,        32'h11223344, 14, 15, 1'b0, 4'hF, 32'h0,        32'h11223344};
        vecs[13] = '{1'b0, 3'b010, 32'h14,  32'h0,        32'h55667788, 15, 15, 1'b1, 4'hF, 32'h0,        32'h11223344};
        vecs[14] = '{1'b0, 3'b001, 32'h3,   32'h0,        32'h0,        0,  0,  1'b1, 4'h0, 32'h0,        32'h11223344};

        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b0;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'(0));
        check("reset req_we_done_err", {28'h0, mem_req, mem_we, done, err}, 32'h0);
        check("reset mem_be", 32'(mem_be), 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset rdata", rdata, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_txn($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd,
                    vecs[i].mrd, vecs[i].waits, 1'b0, vecs[i].exp_nreq, vecs[i].exp_err,
                    vecs[i].exp_be, vecs[i].exp_wd, vecs[i].exp_rd);
        model_rdata = 32'h11223344;

        // start held during REQ and RESP must not relatch or launch a second access
        run_txn("spam_start", 1'b0, 3'b010, 32'h20, 32'h0, 32'hA5A5_0001, 3, 1'b1,
                4, 1'b0, 4'hF, 32'h0, 32'hA5A5_0001);
        model_rdata = 32'hA5A5_0001;

        // mem_ack while idle: nothing happens
        stray = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            mem_ack = 1'b0;
            if (done || busy || mem_req) stray = 1'b1;
        end
        check("idle_ack quiet", 32'(stray), 32'(0));
        check("idle_ack rdata", rdata, model_rdata);

        // reset in the middle of REQ
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h30;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_req mem_req_before", 32'(mem_req), 32'(1));
        rst_n = 1'b0;
        #1;
        check("mid_req mem_req_drop", 32'(mem_req), 32'(0));
        check("mid_req busy_drop", 32'(busy), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_rdata = 32'h0;
        stray = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || mem_req || busy) stray = 1'b1;
        end
        check("post_reset quiet", 32'(stray), 32'(0));
        run_txn("post_reset_txn", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0BAD_F00D, 1, 1'b0,
                2, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D);
        model_rdata = 32'h0BAD_F00D;

        // randomized accesses against the reference model
        for (int i = 0; i < 40; i++) begin
            st  = 1'($urandom % 2);
            f3  = 3'($urandom % 8);
            a   = $urandom;
            if ($urandom % 2 == 1) a = a & 32'hFFFF_FFFC;
            wd  = $urandom;
            mrd = $urandom;
            waits = ($urandom % 8 == 0) ? 20 : int'($urandom % 5);
            model(st, f3, a, wd, mrd, legal, m_be, m_wd, m_ld);
            enr  = !legal ? 0 : (waits < MW ? waits + 1 : MW);
            eerr = !legal || waits >= MW;
            if (legal && !st && waits < MW) model_rdata = m_ld;
            run_txn($sformatf("rnd%0d", i), st, f3, a, wd, mrd, waits, 1'b0,
                    enr, eerr, m_be, m_wd, model_rdata);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
